// File: rtl/otter_iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the OTTER MMIO bus.
// TX FIFO, control/status registers, and a registered serialiser with a drain interrupt.
module otter_iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_in,
  output logic        tx,
  output logic        intrpt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_next;
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_next;
  logic           ovf, ctrl_en, ctrl_irq, irq_next;
  logic [15:0]    bauddiv;
  logic [15:0]    div_q, div_next, baud_cnt, baud_next;
  logic [2:0]     bit_cnt, bit_next;
  logic [7:0]     shift_q, shift_next;
  logic           tx_next;
  logic           sel, wr_txdata, wr_status, wr_ctrl, wr_baud;
  logic           full, empty, push, pop, baud_done;
  logic           unused_bits;

  assign sel       = (iobus_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = iobus_wr && sel && (iobus_addr[3:2] == 2'd0);
  assign wr_status = iobus_wr && sel && (iobus_addr[3:2] == 2'd1);
  assign wr_ctrl   = iobus_wr && sel && (iobus_addr[3:2] == 2'd2);
  assign wr_baud   = iobus_wr && sel && (iobus_addr[3:2] == 2'd3);
  assign unused_bits = ^{iobus_addr[1:0], iobus_out[31:16]};

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign push       = wr_txdata && !full;
  assign count_next = count + CW'(push) - CW'(pop);
  assign irq_next   = wr_ctrl ? iobus_out[1] : ctrl_irq;
  assign baud_done  = (baud_cnt == div_q - 16'd1);

  always_comb begin
    iobus_in = 32'h0;
    if (sel) begin
      case (iobus_addr[3:2])
        2'd1:    iobus_in = 32'({count, ovf, empty, full, (state != IDLE)});
        2'd2:    iobus_in = {30'b0, ctrl_irq, ctrl_en};
        2'd3:    iobus_in = {16'b0, bauddiv};
        default: iobus_in = 32'h0;
      endcase
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= iobus_out[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      ctrl_en  <= 1'b0;
      ctrl_irq <= 1'b0;
      bauddiv  <= DEFAULT_DIV;
      intrpt   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (wr_txdata && full)
        ovf <= 1'b1;
      else if (wr_status && iobus_out[3])
        ovf <= 1'b0;
      if (wr_ctrl) begin
        ctrl_en  <= iobus_out[0];
        ctrl_irq <= iobus_out[1];
      end
      if (wr_baud) bauddiv <= iobus_out[15:0];
      // Built from post-edge values so a push drops the interrupt on its own edge.
      intrpt <= irq_next && (count_next == '0) && (state_next == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift_q  <= 8'h0;
      div_q    <= 16'd1;
      baud_cnt <= 16'd0;
      bit_cnt  <= 3'd0;
    end else begin
      state    <= state_next;
      tx       <= tx_next;
      shift_q  <= shift_next;
      div_q    <= div_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
    end
  end

  // tx_next is the line level for the cycle after the edge, keeping tx a clean flop output.
  always_comb begin
    state_next = state;
    tx_next    = tx;
    shift_next = shift_q;
    div_next   = div_q;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (ctrl_en && !empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          div_next   = (bauddiv == 16'd0) ? 16'd1 : bauddiv;
          baud_next  = 16'd0;
          bit_next   = 3'd0;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = 16'd0;
          tx_next    = shift_q[0];
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = 16'd0;
          if (bit_cnt == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shift_next = {1'b0, shift_q[7:1]};
            tx_next    = shift_q[1];
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next  = 16'd0;
          tx_next    = 1'b1;
          state_next = IDLE;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Directed bench for otter_iobus_uart_tx: register access, FIFO overflow, framing,
// interrupt behaviour, baud shadowing, address decode and asynchronous reset.
module tb_otter_iobus_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic        tx;
  logic        intrpt;

  int checks = 0;
  int errors = 0;

  otter_iobus_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iobus_addr(iobus_addr),
    .iobus_out (iobus_out),
    .iobus_wr  (iobus_wr),
    .iobus_in  (iobus_in),
    .tx        (tx),
    .intrpt    (intrpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle bus store; the write lands on the rising edge inside the task.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    @(negedge clk);
    iobus_wr   = 1'b0;
    iobus_out  = 32'h0;
  endtask

  task automatic checkRead(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    iobus_wr   = 1'b0;
    iobus_addr = addr;
    #1;
    checkOutput(iobus_in, exp, tag);
  endtask

  // Samples one frame cycle by cycle starting at the first start-bit cycle (minus skip).
  task automatic checkFrame(input logic [7:0] b, input int div, input int skip, input string tag);
    int n, bad, bitpos;
    logic [7:0] rx;
    logic exp_bit, busy_seen;
    iobus_wr   = 1'b0;
    iobus_addr = BASE + 32'h4;
    n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(32'(tx), 32'h0, {tag, " start"});
    bad = 0;
    rx = 8'h0;
    busy_seen = 1'b0;
    for (int i = skip; i < 10 * div; i++) begin
      bitpos = i / div;
      if (bitpos == 0)      exp_bit = 1'b0;
      else if (bitpos == 9) exp_bit = 1'b1;
      else                  exp_bit = b[bitpos-1];
      if (tx !== exp_bit) bad++;
      if (bitpos >= 1 && bitpos <= 8 && (i % div) == 0) rx[bitpos-1] = tx;
      if (i == 5 * div) busy_seen = iobus_in[0];
      @(negedge clk);
    end
    checkOutput(32'(bad), 32'h0, {tag, " bad cycles"});
    checkOutput(32'(rx), 32'(b), {tag, " byte"});
    checkOutput(32'(busy_seen), 32'h1, {tag, " busy"});
  endtask

  initial begin
    int stray;
    rst_n      = 1'b0;
    iobus_addr = 32'h0;
    iobus_out  = 32'h0;
    iobus_wr   = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput(32'(tx), 32'h1, "rst tx");
    checkOutput(32'(intrpt), 32'h0, "rst intrpt");
    checkRead(BASE + 32'h4, 32'h4, "rst status");
    checkRead(BASE + 32'hC, 32'd868, "rst bauddiv");
    checkRead(BASE + 32'h8, 32'h0, "rst ctrl");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single frame 0xA5 at div 4");
    applyStimulus(BASE + 32'hC, 32'd4);
    applyStimulus(BASE + 32'h8, 32'h1);
    checkRead(BASE + 32'h8, 32'h1, "ctrl readback");
    checkRead(BASE + 32'h0, 32'h0, "txdata reads 0");
    applyStimulus(BASE + 32'h0, 32'hA5);
    checkOutput(32'(tx), 32'h1, "latency tx high");
    @(negedge clk);
    checkOutput(32'(tx), 32'h0, "latency tx low");
    checkFrame(8'hA5, 4, 0, "frameA5");
    checkRead(BASE + 32'h4, 32'h4, "after A5 status");

    $display("[TB] overflow and FIFO order");
    applyStimulus(BASE + 32'h8, 32'h0);
    applyStimulus(BASE + 32'hC, 32'd2);
    for (int i = 0; i < 17; i++) applyStimulus(BASE + 32'h0, 32'(8'h10 + i));
    checkRead(BASE + 32'h4, 32'h10A, "full status");
    applyStimulus(BASE + 32'h4, 32'h8);
    checkRead(BASE + 32'h4, 32'h102, "ovf cleared");
    applyStimulus(BASE + 32'h8, 32'h1);
    for (int i = 0; i < 16; i++) checkFrame(8'(8'h10 + i), 2, 0, $sformatf("fifo%0d", i));
    checkRead(BASE + 32'h4, 32'h4, "fifo drained");
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) stray++;
    end
    checkOutput(32'(stray), 32'h0, "no 17th frame");

    $display("[TB] interrupt");
    applyStimulus(BASE + 32'h8, 32'h3);
    checkOutput(32'(intrpt), 32'h1, "irq idle empty");
    applyStimulus(BASE + 32'h0, 32'h3C);
    checkOutput(32'(intrpt), 32'h0, "irq after push");
    applyStimulus(BASE + 32'h0, 32'hC3);
    checkFrame(8'h3C, 2, 0, "frame3C");
    checkOutput(32'(intrpt), 32'h0, "irq between frames");
    checkFrame(8'hC3, 2, 0, "frameC3");
    checkOutput(32'(intrpt), 32'h1, "irq drained");
    applyStimulus(BASE + 32'h0, 32'h99);
    checkOutput(32'(intrpt), 32'h0, "irq cleared by push");
    checkFrame(8'h99, 2, 0, "frame99");

    $display("[TB] baud shadowing");
    applyStimulus(BASE + 32'hC, 32'd8);
    applyStimulus(BASE + 32'h0, 32'h5A);
    applyStimulus(BASE + 32'h0, 32'h81);
    applyStimulus(BASE + 32'hC, 32'd2);
    checkFrame(8'h5A, 8, 1, "frame5A div8");
    checkFrame(8'h81, 2, 0, "frame81 div2");
    applyStimulus(BASE + 32'hC, 32'd0);
    applyStimulus(BASE + 32'h0, 32'hE7);
    checkFrame(8'hE7, 1, 0, "frameE7 div0");
    checkRead(BASE + 32'hC, 32'h0, "bauddiv zero readback");

    $display("[TB] unselected addresses");
    applyStimulus(BASE + 32'h10, 32'hFF);
    applyStimulus(BASE + 32'h18, 32'h0);
    checkRead(BASE + 32'h10, 32'h0, "unsel read");
    checkRead(BASE + 32'h14, 32'h0, "unsel status read");
    checkRead(BASE + 32'h4, 32'h4, "unsel status");
    checkRead(BASE + 32'h8, 32'h3, "unsel ctrl");
    @(negedge clk);
    checkOutput(32'(tx), 32'h1, "unsel tx idle");

    $display("[TB] reset mid-frame");
    applyStimulus(BASE + 32'hC, 32'd4);
    applyStimulus(BASE + 32'h0, 32'h00);
    applyStimulus(BASE + 32'h0, 32'h22);
    repeat (7) @(negedge clk);
    checkOutput(32'(tx), 32'h0, "pre-reset tx low");
    rst_n = 1'b0;
    #1;
    checkOutput(32'(tx), 32'h1, "async rst tx");
    checkOutput(32'(intrpt), 32'h0, "async rst intrpt");
    checkRead(BASE + 32'h4, 32'h4, "async rst status");
    checkRead(BASE + 32'hC, 32'd868, "async rst bauddiv");
    checkRead(BASE + 32'h8, 32'h0, "async rst ctrl");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput(32'(tx), 32'h1, "post-reset tx idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
